// File: rtl/fft_drain_ctrl_pkg.sv
// Shared FFT buffer definitions: default widths (common with the fill counter),
// drain FSM encoding and the read-credit rule.
package fft_drain_ctrl_pkg;

  localparam int unsigned FFT_ADDR_W = 7;
  localparam int unsigned FFT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

  // A new read may start only if the word in flight, the words already
  // buffered and the word leaving this cycle still leave a free slot.
  function automatic logic credit_ok(input logic       inflight,
                                     input logic [1:0] occ,
                                     input logic       pop);
    logic [2:0] used;
    used = {2'b00, inflight} + {1'b0, occ} - {2'b00, pop};
    return (used < 3'd2);
  endfunction

endpackage

// File: rtl/fft_drain_ctrl_if.sv
// Bundle of the drain block's control, RAM read port and output stream.
// The master side is the drain controller; the slave side is its environment.
interface fft_drain_ctrl_if
  import fft_drain_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = FFT_ADDR_W,
  parameter int unsigned DATA_W = FFT_DATA_W
);

  logic [ADDR_W-1:0] thresh;
  logic              full;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              empty;
  logic              done;

  modport master (
    input  thresh, full, rd_data, out_ready,
    output rd_en, rd_addr, out_valid, out_data, out_last, empty, done
  );

  modport slave (
    output thresh, full, rd_data, out_ready,
    input  rd_en, rd_addr, out_valid, out_data, out_last, empty, done
  );

endinterface

// File: rtl/fft_drain_ctrl_skid_fifo.sv
// Two-entry FIFO of {last, data} that absorbs the RAM read latency when the
// downstream stage stalls. The caller guarantees no push into a full FIFO.
module drain_skid_fifo #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path infers a latch.
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (push_i) begin
      if (wr_ptr_q) begin
        entry1_d = push_data_i;
      end else begin
        entry0_d = push_data_i;
      end
      wr_ptr_d = ~wr_ptr_q;
    end

    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    occ_d = occ_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  // NOTE: storage is reset as well, so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_o = rd_ptr_q ? entry1_q : entry0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fft_drain_ctrl.sv
// Read-side sequencer for the FFT sample buffer: latches the frame length on
// `full`, issues sequential RAM reads and streams the words out with backpressure.
module fft_drain_ctrl
  import fft_drain_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = FFT_ADDR_W,
  parameter int unsigned DATA_W = FFT_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_drain_ctrl_if.master    bus
);

  drain_state_e      state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic              last_tag_q, last_tag_d;
  logic              done_q, done_d;

  logic              rd_en;
  logic              is_last_issue;
  logic              out_valid;
  logic              pop;
  logic [1:0]        fifo_occ;
  logic [DATA_W:0]   fifo_head;

  assign out_valid     = (fifo_occ != 2'd0);
  assign pop           = out_valid & bus.out_ready;
  assign is_last_issue = (cnt_q == len_q - ADDR_W'(1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.full && (bus.thresh != '0)) begin
          state_d = ST_DRAIN;
          len_d   = bus.thresh;
          cnt_d   = '0;
        end
      end

      ST_DRAIN: begin
        if (credit_ok(inflight_q, fifo_occ, pop)) begin
          rd_en = 1'b1;
          cnt_d = cnt_q + ADDR_W'(1);
          if (is_last_issue) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        // The tagged word leaving the FIFO closes the frame.
        if (pop && fifo_head[DATA_W]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inflight_d = rd_en;
    last_tag_d = rd_en & is_last_issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      last_tag_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      last_tag_q <= last_tag_d;
      done_q     <= done_d;
    end
  end

  // The RAM answers one cycle after rd_en, so the in-flight flag is the push.
  drain_skid_fifo #(
    .WIDTH (DATA_W + 1)
  ) u_skid_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i ({last_tag_q, bus.rd_data}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .occ_o       (fifo_occ)
  );

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = cnt_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = fifo_head[DATA_W-1:0];
  assign bus.out_last  = fifo_head[DATA_W];
  assign bus.empty     = (state_q == ST_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fft_drain_ctrl.sv
// Self-checking bench for fft_drain_ctrl: a one-cycle-latency RAM model feeds
// the DUT and a frame-level reference model predicts every output each cycle.
module tb_fft_drain_ctrl;

  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fft_drain_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fft_drain_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame progress expressed as sample counts.
  bit          m_active;
  bit          m_done_exp;
  int          m_len;
  int          m_issued;
  int          m_arrived;
  int          m_delivered;

  logic [31:0] salt;
  bit          pend_v;
  int          pend_a;
  bit          prev_hold;
  logic [DW-1:0] prev_data;
  logic        prev_last;
  int          done_seen;
  int          xfer_seen;
  int          rd_seen;

  function automatic logic [DW-1:0] ram_word(input int a);
    return DW'(a * 10) + salt;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_done_exp  = 1'b0;
    m_len       = 0;
    m_issued    = 0;
    m_arrived   = 0;
    m_delivered = 0;
    pend_v      = 1'b0;
    pend_a      = 0;
    prev_hold   = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_en",     bus.rd_en,     1'b0);
    check("rst_rd_addr",   bus.rd_addr,   '0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  '0);
    check("rst_out_last",  bus.out_last,  1'b0);
    check("rst_empty",     bus.empty,     1'b1);
    check("rst_done",      bus.done,      1'b0);
  endtask

  // One clock cycle: entered just after a rising edge with inputs already set.
  task automatic run_cycle();
    bit exp_valid, exp_pop, exp_rd_en, nxt_active, nxt_done;
    int occ;
    bus.rd_data = pend_v ? ram_word(pend_a) : DW'($urandom);
    @(negedge clk);

    occ       = m_arrived - m_delivered;
    exp_valid = (occ > 0);
    exp_pop   = exp_valid && bus.out_ready;
    exp_rd_en = m_active && (m_issued < m_len) &&
                ((m_issued - m_delivered - int'(exp_pop)) < 2);

    check("out_valid", bus.out_valid, exp_valid);
    check("rd_en", bus.rd_en, exp_rd_en);
    if (exp_rd_en && bus.rd_en)
      check("rd_addr", bus.rd_addr, m_issued);
    if (exp_valid && bus.out_valid) begin
      check("out_data", bus.out_data, ram_word(m_delivered));
      check("out_last", bus.out_last, (m_delivered == m_len - 1));
    end
    if (prev_hold && bus.out_valid) begin
      check("hold_data", bus.out_data, prev_data);
      check("hold_last", bus.out_last, prev_last);
    end
    check("empty", bus.empty, !m_active);
    check("done", bus.done, m_done_exp);

    done_seen += int'(bus.done);
    xfer_seen += int'(bus.out_valid && bus.out_ready);
    rd_seen   += int'(bus.rd_en);
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
    prev_last = bus.out_last;
    pend_v    = bus.rd_en;
    pend_a    = int'(bus.rd_addr);

    nxt_done   = 1'b0;
    nxt_active = m_active;
    if (!m_active) begin
      if (bus.full && (bus.thresh != '0)) begin
        nxt_active  = 1'b1;
        m_len       = int'(bus.thresh);
        m_issued    = 0;
        m_arrived   = 0;
        m_delivered = 0;
      end
    end else begin
      m_arrived = m_issued;
      m_issued += int'(exp_rd_en);
      if (exp_pop) begin
        m_delivered++;
        if (m_delivered == m_len) begin
          nxt_active = 1'b0;
          nxt_done   = 1'b1;
        end
      end
    end
    m_active   = nxt_active;
    m_done_exp = nxt_done;

    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int len);
    bus.full      = 1'b1;
    bus.thresh    = AW'(len);
    bus.out_ready = 1'b1;
    run_cycle();
    bus.full      = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input bit rand_ready);
    int n;
    n = 0;
    bus.full = 1'b0;
    while ((m_active || m_done_exp) && (n < budget)) begin
      bus.out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      run_cycle();
      n++;
    end
    if (m_active || m_done_exp)
      check("frame_timeout", 1'b1, 1'b0);
  endtask

  task automatic clear_counts();
    done_seen = 0;
    xfer_seen = 0;
    rd_seen   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.full      = 1'b0;
    bus.thresh    = '0;
    bus.out_ready = 1'b0;
    bus.rd_data   = '0;
    salt          = 32'd0;
    model_reset();
    clear_counts();
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame: RAM holds 10*addr.
    clear_counts();
    start_frame(4);
    run_until_idle(20, 1'b0);
    check("basic_done_cnt", done_seen, 1);
    check("basic_xfers", xfer_seen, 4);

    // Backpressure: ready low for cycles 4..7 after the start edge.
    clear_counts();
    salt = $urandom;
    start_frame(8);
    for (int c = 1; c <= 25; c++) begin
      bus.out_ready = !((c >= 4) && (c <= 7));
      run_cycle();
    end
    check("bp_done_cnt", done_seen, 1);
    check("bp_xfers", xfer_seen, 8);

    // Zero length is ignored.
    clear_counts();
    bus.full   = 1'b1;
    bus.thresh = '0;
    for (int c = 0; c < 5; c++) run_cycle();
    bus.full = 1'b0;
    run_cycle();
    check("zero_rd_cnt", rd_seen, 0);
    check("zero_done_cnt", done_seen, 0);

    // full and thresh changes during a frame are ignored.
    clear_counts();
    salt = $urandom;
    start_frame(6);
    for (int c = 0; c < 4; c++) begin
      bus.full      = 1'b1;
      bus.thresh    = AW'(2);
      bus.out_ready = ($urandom_range(3) != 0);
      run_cycle();
    end
    run_until_idle(60, 1'b1);
    run_cycle();
    check("ign_done_cnt", done_seen, 1);
    check("ign_xfers", xfer_seen, 6);

    // Maximum length frame.
    clear_counts();
    salt = $urandom;
    start_frame(127);
    run_until_idle(2000, 1'b1);
    check("max_done_cnt", done_seen, 1);
    check("max_xfers", xfer_seen, 127);
    check("max_reads", rd_seen, 127);

    // Random back-to-back frames.
    for (int f = 0; f < 6; f++) begin
      clear_counts();
      salt = $urandom;
      n = int'($urandom_range(20, 1));
      start_frame(n);
      run_until_idle(400, 1'b1);
      check("rnd_xfers", xfer_seen, n);
      check("rnd_done_cnt", done_seen, 1);
    end

    // Reset mid-frame after three transfers.
    salt = $urandom;
    start_frame(10);
    n = 0;
    while ((m_delivered < 3) && (n < 50)) begin
      bus.out_ready = 1'b1;
      run_cycle();
      n++;
    end
    check("pre_rst_xfers", m_delivered >= 3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_counts();
    start_frame(3);
    run_until_idle(40, 1'b1);
    check("post_rst_xfers", xfer_seen, 3);
    check("post_rst_done_cnt", done_seen, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_drain_ctrl.md
# fft_drain_ctrl

Read-side sequencer for the FFT sample buffer. It is the counterpart of the fill counter. When the fill side reports `full`, this block latches the frame length and issues sequential read addresses to the registered buffer RAM. It returns the RAM data to the downstream stage over a valid/ready stream, with a 2-entry output buffer that absorbs the one-cycle RAM latency under backpressure.

## Interface
- `ADDR_W`, default 7: width of the read address and the frame-length input.
- `DATA_W`, default 32: width of the sample word.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `thresh`, input, ADDR_W: frame length in samples. Sampled only on the start condition.
- `full`, input, 1: level from the fill side. Starts a drain when the block is idle.
- `rd_en`, output, 1: RAM read strobe.
- `rd_addr`, output, ADDR_W: RAM read address. Meaningful only while `rd_en` is high.
- `rd_data`, input, DATA_W: RAM data, valid in the cycle after `rd_en`.
- `out_valid`, output, 1: stream valid.
- `out_ready`, input, 1: stream ready from downstream.
- `out_data`, output, DATA_W: stream data.
- `out_last`, output, 1: marks the final sample of the frame.
- `empty`, output, 1: high while idle.
- `done`, output, 1: one-cycle pulse when the frame is fully delivered.

## Operation
- States:
  - IDLE: `empty`=1.
  - DRAIN: issuing reads.
  - FLUSH: all reads issued; waiting for the buffer to empty.
- IDLE → DRAIN: when `full`=1 and `thresh`≠0.
  - Latch `len`=`thresh`.
  - Clear the issue count and `rd_addr` to 0.
- `full`=1 with `thresh`=0: ignored; the block stays in IDLE.
- `full` is ignored outside IDLE. `thresh` changes after the latch are ignored.
- Read issue in DRAIN:
  - Condition: `inflight + occupancy − pop < 2`, where `pop` = `out_valid & out_ready`.
  - On issue: `rd_en`=1, `rd_addr`=issue count, then the count increments.
  - The issue with count `len`−1 tags that entry as last and moves the state to FLUSH.
- The read returning in the cycle after `rd_en` is written into the 2-entry FIFO together with its last tag.
- Stream output:
  - `out_valid` = FIFO non-empty.
  - `out_data`/`out_last` come from the FIFO head.
  - Transfer occurs when `out_valid & out_ready`.
  - While `out_valid`=1 and `out_ready`=0, `out_data`/`out_last` stay stable.
- FLUSH → IDLE: in the cycle after the transfer with `out_last`=1. `done`=1 in that same cycle.
- Addresses run from 0 to `len`−1 and never wrap within a frame. `len`=2^ADDR_W−1 is legal.
- Reset at any time clears everything; any pending frame is discarded.

## Timing
- Reset values:
  - State = IDLE.
  - `empty`=1.
  - `rd_en`=0, `rd_addr`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `done`=0.
  - FIFO empty, inflight=0.
- Latency:
  - `full` sampled high in IDLE at edge 0.
  - First `rd_en`/`rd_addr`=0 in cycle 1.
  - `rd_data` in cycle 2.
  - `out_valid`=1 in cycle 3.
- Throughput: one sample per cycle with `out_ready` held high.
- Backpressure: occupancy never exceeds 2 and no sample is dropped. `rd_en` resumes in the same cycle `out_ready` rises.
- Frame timing: `empty` falls in cycle 1 and rises with `done`.
- A new frame may start at the earliest in the cycle after `done`.

## Structure
- Shared FFT package:
  - State encoding: IDLE, DRAIN, FLUSH.
  - `ADDR_W`/`DATA_W` defaults, shared with the fill counter.
- Sub-module `drain_skid_fifo`: 2-entry FIFO of `{last, data}` with push/pop and occupancy output.
- FSM, issue counter, inflight flag and credit check stay in the top module.

## Test plan
- Basic frame: `thresh`=4, `full` pulse, `out_ready`=1, RAM returns 10·addr.
  - `rd_addr` = 0,1,2,3 on cycles 1–4.
  - `out_data` = 0,10,20,30 on cycles 3–6.
  - `out_last` on 30.
  - `done` on cycle 7, with `empty`=1.
- Backpressure: `thresh`=8, `out_ready` low for cycles 4–7.
  - `out_data` held stable.
  - `rd_en` stalls with occupancy 2.
  - All 8 samples delivered in order, none duplicated.
- Zero length: `thresh`=0 with `full`=1 for 5 cycles → no `rd_en`, `empty` stays 1, no `done`.
- Ignored inputs during DRAIN: `full` re-asserted and `thresh` changed to 2 during a `thresh`=6 frame → exactly 6 samples, one `done`.
- Maximum length: `thresh`=127 → addresses 0..126, `out_last` only on addr 126, no wrap to 0.
- Reset mid-frame: assert `rst_n`=0 after 3 transfers → all outputs at reset values immediately. A new frame after release starts at addr 0.
